// File: rtl/edu_share_arbiter_if.sv
// Channel bundle between requesters, the shared EDU and the arbiter.
// The slave modport is the arbiter side; the master modport is the environment side.
interface edu_share_arbiter_if #(
  parameter int W     = 11,
  parameter int NREQ  = 2,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      edu_in_data;
  logic              edu_in_valid;
  logic              edu_in_ready;
  logic [W-1:0]      edu_out_data;
  logic              edu_out_valid;
  logic              edu_out_ready;
  logic [W-1:0]      rsp_data;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [CW-1:0]     outstanding;
  logic              err_orphan;

  modport slave (
    input  req_data, req_valid, edu_in_ready, edu_out_data, edu_out_valid, rsp_ready,
    output req_ready, edu_in_data, edu_in_valid, edu_out_ready, rsp_data, rsp_valid,
    output outstanding, err_orphan
  );

  modport master (
    output req_data, req_valid, edu_in_ready, edu_out_data, edu_out_valid, rsp_ready,
    input  req_ready, edu_in_data, edu_in_valid, edu_out_ready, rsp_data, rsp_valid,
    input  outstanding, err_orphan
  );
endinterface

// File: rtl/edu_share_arbiter.sv
// Round-robin arbiter sharing one EDU between NREQ requesters; a tag FIFO
// remembers the issuer of each in-flight job so in-order results are steered back.
module edu_share_arbiter #(
  parameter int W     = 11,
  parameter int NREQ  = 2,
  parameter int DEPTH = 4,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic               CLK,
  input logic               _RESET,
  edu_share_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]    r_in_data;
  logic            r_in_valid;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_tag [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_orphan;
  logic            r_active;

  logic            w_can_accept;
  logic            w_found;
  logic            w_grant;
  logic [IDW-1:0]  w_gid;
  logic [W-1:0]    w_gdata;
  logic [NREQ-1:0] w_req_ready;
  logic            w_empty;
  logic [IDW-1:0]  w_head;
  logic [NREQ-1:0] w_rsp_valid;
  logic            w_out_ready;
  logic            w_pop;

  // r_active keeps req_ready low from reset until the first clock edge after release.
  assign w_can_accept = r_active && (!r_in_valid || bus.edu_in_ready) &&
                        (r_count < CW'(DEPTH));

  always_comb begin : p_grant
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_gid   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && bus.req_valid[idx]) begin
        w_found = 1'b1;
        w_gid   = IDW'(idx);
      end
    end
    w_grant     = w_found && w_can_accept;
    w_req_ready = '0;
    if (w_grant) w_req_ready[w_gid] = 1'b1;
  end

  assign w_gdata = bus.req_data[w_gid*W +: W];

  assign w_empty = (r_count == '0);
  assign w_head  = r_tag[r_rd_ptr];

  always_comb begin
    w_rsp_valid = '0;
    if (bus.edu_out_valid && !w_empty) w_rsp_valid[w_head] = 1'b1;
  end

  assign w_out_ready = !w_empty && bus.rsp_ready[w_head];
  assign w_pop       = bus.edu_out_valid && w_out_ready;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      r_in_data  <= '0;
      r_in_valid <= 1'b0;
      r_ptr      <= IDW'(NREQ - 1);
      r_active   <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (w_grant) begin
        r_in_data  <= w_gdata;
        r_in_valid <= 1'b1;
        r_ptr      <= w_gid;
      end else if (r_in_valid && bus.edu_in_ready) begin
        r_in_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_orphan <= 1'b0;
    end else begin
      if (w_grant) begin
        r_tag[r_wr_ptr] <= w_gid;
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      end
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (bus.edu_out_valid && w_empty) r_orphan <= 1'b1;
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.edu_in_data   = r_in_data;
  assign bus.edu_in_valid  = r_in_valid;
  assign bus.edu_out_ready = w_out_ready;
  assign bus.rsp_data      = bus.edu_out_data;
  assign bus.rsp_valid     = w_rsp_valid;
  assign bus.outstanding   = r_count;
  assign bus.err_orphan    = r_orphan;
endmodule

// File: tb/tb_edu_share_arbiter.sv
// Directed bench for edu_share_arbiter: W=11, NREQ=2, DEPTH=4.
module tb_edu_share_arbiter;
  localparam int W = 11;
  localparam int NREQ = 2;
  localparam int DEPTH = 4;

  logic CLK;
  logic rst_n;
  int   n_chk;
  int   n_err;

  edu_share_arbiter_if #(.W(W), .NREQ(NREQ), .DEPTH(DEPTH)) bus ();

  edu_share_arbiter #(.W(W), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    ._RESET (rst_n),
    .bus    (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int r, input logic [W-1:0] d);
    bus.req_data[r*W +: W] = d;
  endtask

  task automatic clear_inputs();
    bus.req_data      = '0;
    bus.req_valid     = '0;
    bus.edu_in_ready  = 1'b0;
    bus.edu_out_data  = '0;
    bus.edu_out_valid = 1'b0;
    bus.rsp_ready     = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    clear_inputs();
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("rst_in_valid", 32'(bus.edu_in_valid), 0);
    chk("rst_in_data", 32'(bus.edu_in_data), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_outstanding", 32'(bus.outstanding), 0);
    chk("rst_orphan", 32'(bus.err_orphan), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    #11;
    rst_n = 1'b1;
    #1;
    chk("post_release_ready", 32'(bus.req_ready), 0);
    step();
    chk("first_priority_req0", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;

    // single requester stream 5,6,7
    bus.edu_in_ready = 1'b1;
    bus.rsp_ready    = 2'b11;
    bus.req_valid    = 2'b01;
    set_req(0, 11'd5);
    #1;
    chk("single_ready0", 32'(bus.req_ready), 32'h1);
    step();
    chk("single_in5_v", 32'(bus.edu_in_valid), 1);
    chk("single_in5_d", 32'(bus.edu_in_data), 5);
    chk("single_out1", 32'(bus.outstanding), 1);
    set_req(0, 11'd6);
    step();
    chk("single_in6_d", 32'(bus.edu_in_data), 6);
    chk("single_out2", 32'(bus.outstanding), 2);
    set_req(0, 11'd7);
    step();
    chk("single_in7_d", 32'(bus.edu_in_data), 7);
    chk("single_out3", 32'(bus.outstanding), 3);
    bus.req_valid = '0;
    step();
    chk("single_in_idle", 32'(bus.edu_in_valid), 0);
    for (int i = 5; i <= 7; i++) begin
      bus.edu_out_valid = 1'b1;
      bus.edu_out_data  = W'(i);
      #1;
      chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("single_rsp_data", 32'(bus.rsp_data), 32'(i));
      chk("single_out_ready", 32'(bus.edu_out_ready), 1);
      step();
    end
    bus.edu_out_valid = 1'b0;
    chk("single_out0", 32'(bus.outstanding), 0);

    // fairness: alternate grants from requester 0
    do_reset();
    bus.edu_in_ready = 1'b1;
    bus.rsp_ready    = 2'b11;
    bus.req_valid    = 2'b11;
    set_req(0, 11'h100);
    set_req(1, 11'h200);
    #1;
    chk("fair_g0", 32'(bus.req_ready), 32'h1);
    step();
    chk("fair_in0", 32'(bus.edu_in_data), 32'h100);
    set_req(0, 11'h101);
    #1;
    chk("fair_g1", 32'(bus.req_ready), 32'h2);
    step();
    chk("fair_in1", 32'(bus.edu_in_data), 32'h200);
    #1;
    chk("fair_g2", 32'(bus.req_ready), 32'h1);
    step();
    chk("fair_in2", 32'(bus.edu_in_data), 32'h101);
    set_req(1, 11'h201);
    #1;
    chk("fair_g3", 32'(bus.req_ready), 32'h2);
    step();
    chk("fair_in3", 32'(bus.edu_in_data), 32'h201);
    chk("fair_full", 32'(bus.outstanding), 4);
    bus.req_valid = '0;
    bus.edu_out_valid = 1'b1;
    bus.edu_out_data = 11'h100;
    #1;
    chk("fair_rsp0", 32'(bus.rsp_valid), 32'h1);
    step();
    bus.edu_out_data = 11'h200;
    #1;
    chk("fair_rsp1", 32'(bus.rsp_valid), 32'h2);
    step();
    bus.edu_out_data = 11'h101;
    #1;
    chk("fair_rsp2", 32'(bus.rsp_valid), 32'h1);
    step();
    bus.edu_out_data = 11'h201;
    #1;
    chk("fair_rsp3", 32'(bus.rsp_valid), 32'h2);
    chk("fair_rsp3_data", 32'(bus.rsp_data), 32'h201);
    step();
    bus.edu_out_valid = 1'b0;
    chk("fair_drain", 32'(bus.outstanding), 0);

    // full: four accepts then stall
    do_reset();
    bus.edu_in_ready = 1'b1;
    bus.rsp_ready    = 2'b11;
    bus.req_valid    = 2'b01;
    for (int i = 0; i < 6; i++) begin
      set_req(0, W'(32'h40 + i));
      #1;
      chk("full_ready", 32'(bus.req_ready), (i < 4) ? 32'h1 : 32'h0);
      step();
    end
    chk("full_out4", 32'(bus.outstanding), 4);
    set_req(0, 11'h77);
    bus.edu_out_valid = 1'b1;
    bus.edu_out_data  = 11'h40;
    #1;
    chk("full_pop_no_same", 32'(bus.req_ready), 0);
    chk("full_pop_ready", 32'(bus.edu_out_ready), 1);
    step();
    bus.edu_out_valid = 1'b0;
    chk("full_out3", 32'(bus.outstanding), 3);
    #1;
    chk("full_resume", 32'(bus.req_ready), 32'h1);
    step();
    chk("full_out4b", 32'(bus.outstanding), 4);
    chk("full_resume_data", 32'(bus.edu_in_data), 32'h77);

    // EDU input backpressure
    do_reset();
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b10;
    set_req(1, 11'h2A);
    #1;
    chk("bp_ready1", 32'(bus.req_ready), 32'h2);
    step();
    chk("bp_valid", 32'(bus.edu_in_valid), 1);
    set_req(1, 11'h2B);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_no_accept", 32'(bus.req_ready), 0);
      step();
      chk("bp_hold_data", 32'(bus.edu_in_data), 32'h2A);
      chk("bp_hold_valid", 32'(bus.edu_in_valid), 1);
    end
    chk("bp_out1", 32'(bus.outstanding), 1);
    bus.req_valid = '0;
    bus.edu_in_ready = 1'b1;
    step();
    chk("bp_released", 32'(bus.edu_in_valid), 0);
    chk("bp_out1b", 32'(bus.outstanding), 1);

    // head-of-line blocking
    do_reset();
    bus.edu_in_ready = 1'b1;
    bus.req_valid = 2'b01;
    set_req(0, 11'd1);
    step();
    bus.req_valid = 2'b10;
    set_req(1, 11'd2);
    step();
    bus.req_valid = '0;
    step();
    chk("hol_out2", 32'(bus.outstanding), 2);
    bus.rsp_ready = 2'b10;
    bus.edu_out_valid = 1'b1;
    bus.edu_out_data  = 11'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hol_stall_ready", 32'(bus.edu_out_ready), 0);
      chk("hol_stall_valid", 32'(bus.rsp_valid), 32'h1);
      step();
    end
    chk("hol_out2b", 32'(bus.outstanding), 2);
    bus.rsp_ready = 2'b11;
    #1;
    chk("hol_rel_ready", 32'(bus.edu_out_ready), 1);
    chk("hol_rel_rsp0", 32'(bus.rsp_valid), 32'h1);
    step();
    bus.edu_out_data = 11'd2;
    #1;
    chk("hol_rsp1", 32'(bus.rsp_valid), 32'h2);
    chk("hol_rsp1_data", 32'(bus.rsp_data), 2);
    step();
    bus.edu_out_valid = 1'b0;
    chk("hol_out0", 32'(bus.outstanding), 0);

    // orphan result, then reset mid-burst
    bus.edu_out_valid = 1'b1;
    bus.edu_out_data  = 11'h3FF;
    #1;
    chk("orph_no_rsp", 32'(bus.rsp_valid), 0);
    chk("orph_no_ready", 32'(bus.edu_out_ready), 0);
    chk("orph_pre", 32'(bus.err_orphan), 0);
    step();
    chk("orph_set", 32'(bus.err_orphan), 1);
    bus.edu_out_valid = 1'b0;
    step();
    chk("orph_sticky", 32'(bus.err_orphan), 1);
    bus.req_valid = 2'b01;
    set_req(0, 11'h55);
    step();
    step();
    chk("burst_out2", 32'(bus.outstanding), 2);
    bus.edu_out_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_valid", 32'(bus.edu_in_valid), 0);
    chk("mid_rst_in_data", 32'(bus.edu_in_data), 0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 0);
    chk("mid_rst_outstanding", 32'(bus.outstanding), 0);
    chk("mid_rst_orphan", 32'(bus.err_orphan), 0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    clear_inputs();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/edu_share_arbiter.md
Name: edu_share_arbiter

Overview:
Synchronous round-robin arbiter that shares one EDU datapath instance between NREQ requesters. It accepts one request per cycle into a registered issue stage and drives the EDU input channel. A tag FIFO records the requester ID of each in-flight transaction, and EDU results, which return in order, are steered back to the issuing requester. The block sits between the requester-side channel adapters and the EDU cosim wrapper in the co-simulation and NoC integration fabric.

Parameters:
W, 11, data width of request and result words
NREQ, 2, number of requesters (2..8)
DEPTH, 4, maximum outstanding EDU transactions (tag FIFO depth, power of 2)
IDW, 1, requester ID width, equal to max(1, clog2(NREQ))

Ports:
CLK  in  1  clock, rising edge
_RESET  in  1  asynchronous active-low reset
req_data  in  NREQ*W  request words; requester i occupies [i*W +: W]
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
edu_in_data  out  W  word presented to EDU
edu_in_valid  out  1  EDU input valid
edu_in_ready  in  1  EDU input accept
edu_out_data  in  W  EDU result
edu_out_valid  in  1  EDU result valid
edu_out_ready  out  1  EDU result accept
rsp_data  out  W  result word, broadcast to all requesters
rsp_valid  out  NREQ  per-requester result valid (one-hot or zero)
rsp_ready  in  NREQ  per-requester result accept
outstanding  out  clog2(DEPTH)+1  count of issued but not returned transactions
err_orphan  out  1  sticky: EDU result arrived with empty tag FIFO

Behaviour:
- Reset (_RESET low, asynchronous): edu_in_valid=0, edu_in_data=0, req_ready=0, outstanding=0, err_orphan=0, tag FIFO empty, RR pointer=NREQ-1 (requester 0 has top priority first). Outputs hold these values until the first CLK edge after release.
- Handshake rule on all channels: transfer happens when valid && ready on a rising CLK edge. edu_in_data/edu_in_valid are held stable until transfer.
- can_accept = (!edu_in_valid || edu_in_ready) && (outstanding < DEPTH). A pop in the same cycle does not free a slot for that cycle.
- Grant: when can_accept is true, the first valid requester searched circularly from ptr+1 gets req_ready[g]=1. req_ready is combinational from req_valid, ptr, and state.
- On a grant edge:
  - edu_in_data <= req_data[g], edu_in_valid <= 1, ptr <= g.
  - Push g into the tag FIFO; outstanding increments.
  - Latency: request accept at edge t puts it on edu_in at t+1.
- If edu_in transfers and there is no new grant, edu_in_valid <= 0 on the same edge.
- Back-to-back: with edu_in_ready held high, one request is issued per cycle. Full throughput is sustained.
- Response path: head = tag FIFO head.
  - rsp_valid[head] = edu_out_valid && !empty; all other bits are 0.
  - rsp_data = edu_out_data.
  - edu_out_ready = !empty && rsp_ready[head].
  - On transfer: pop the FIFO; outstanding decrements.
- Simultaneous push and pop: outstanding is unchanged, and the FIFO pointers advance independently.
- Orphan (edu_out_valid && empty):
  - edu_out_ready=0; no rsp_valid is asserted.
  - err_orphan <= 1. It clears only on reset.
- Full: at outstanding=DEPTH, all req_ready=0. Issuing resumes on the cycle after a pop.
- Head requester stalled (rsp_ready[head]=0): the EDU output stalls, and later responses for other requesters also wait. This in-order blocking is intended.
- Reset mid-operation: all in-flight tags are discarded. Upstream and EDU wrappers are reset by the same _RESET.

Test Plan:
- Single requester: req0 sends 5,6,7 with edu_in_ready=1 and an EDU echo model. Required: edu_in carries 5,6,7 on consecutive cycles, each 1 cycle after its accept; rsp_valid=01 with data 5,6,7; outstanding returns to 0.
- Fairness: req0 and req1 valid continuously, values 0x100+n and 0x200+n. Required: grants alternate 0,1,0,1 starting with requester 0; results are routed to the matching requester.
- Full: DEPTH=4, edu_out_valid held 0. Required: exactly 4 accepts, outstanding=4, req_ready=0. Then return one result: a new accept occurs on the next cycle, not the same one.
- Backpressure: edu_in_ready=0 for 3 cycles with req1 valid (0x2A). Required: edu_in_data=0x2A held stable, no further accepts, single transfer when ready rises.
- Head blocking: issue req0=1 then req1=2, and hold rsp_ready[0]=0 for 4 cycles. Required: edu_out_ready=0 and rsp_valid=01 held throughout; after release, 1 goes to req0 and then 2 goes to req1.
- Orphan/reset: drive edu_out_valid with an empty FIFO. Required: err_orphan=1 and no rsp_valid. Then assert _RESET mid-burst: all outputs go to reset values without waiting for a clock edge.
